match_table: RTL and testbench
==============================

Name: match_table

Overview:
- Exact-match lookup stage directly upstream of the action executor in the reconfigurable switch pipeline.
- Extracts a lookup key from the parsed packet header using up to KEY_FIELDS configurable field descriptors, then linearly searches a small register-based table.
- Delivers is_match, action args, and the pass-through header, parsed-header offsets and port to the executor, aligned on a single ready pulse.
- The control plane reconfigures key layout and entries through a mod interface.

Parameters:
- HDR_MAX_LEN, 128, header bytes carried per packet.
- NUM_HEADERS, 16, parsed header offset slots (hdr id 4 bits).
- KEY_FIELDS, 4, field descriptors composing the key.
- MAX_KEY_LEN, 16, key bytes.
- MAX_VAL_LEN, 16, action argument bytes per entry.
- NUM_ENTRIES, 16, table depth.
- NUM_PORTS, 8, port bitmap width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start_i  in  1  packet valid, one-cycle pulse
- pkt_hdr_i  in  8 x HDR_MAX_LEN  header bytes
- parsed_hdrs_i  in  32 x NUM_HEADERS  byte offset of each header
- out_port_i  in  NUM_PORTS  port bitmap from parser
- ready_o  out  1  result valid, one-cycle pulse
- busy_o  out  1  high whenever state is not IDLE
- is_match_o  out  1  hit flag
- hit_idx_o  out  clog2(NUM_ENTRIES)  matching entry index, 0 on miss
- args_o  out  8 x MAX_VAL_LEN  action args of hit entry, all zero on miss
- pkt_hdr_o  out  8 x HDR_MAX_LEN  registered pass-through
- parsed_hdrs_o  out  32 x NUM_HEADERS  registered pass-through
- out_port_o  out  NUM_PORTS  registered pass-through
- mod_start_i  in  1  load key layout
- mod_key_fields_i  in  16 x KEY_FIELDS  descriptor {hdr[15:12], off[11:6], len[5:0]}
- tbl_wr_i  in  1  write one entry
- tbl_wr_idx_i  in  clog2(NUM_ENTRIES)  entry index
- tbl_wr_valid_i  in  1  entry valid bit
- tbl_wr_key_i  in  8 x MAX_KEY_LEN  entry key, zero-padded
- tbl_wr_val_i  in  8 x MAX_VAL_LEN  entry args

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk.
- Reset values:
  - ready_o, busy_o, is_match_o, hit_idx_o, args_o, pkt_hdr_o, parsed_hdrs_o, out_port_o all 0.
  - All entry valid bits 0.
  - All key descriptors 0.
  - State IDLE.
- Entry keys and values are not reset.
- FSM states: IDLE, EXTRACT, SEARCH.
- IDLE:
  - mod_start_i latches all descriptors.
  - tbl_wr_i writes key, value and valid at tbl_wr_idx_i.
  - Both mod_start_i and tbl_wr_i may act in the same cycle.
  - Any mod or table write in a cycle takes precedence; a simultaneous start_i is dropped.
  - Otherwise start_i latches pkt_hdr_i, parsed_hdrs_i and out_port_i into internal regs and moves to EXTRACT.
- EXTRACT (one cycle):
  - Key bytes are concatenated in descriptor order 0..KEY_FIELDS-1.
  - Field k contributes len bytes starting at byte parsed_hdrs[hdr] + off.
  - len 0 contributes nothing.
  - Source bytes at index >= HDR_MAX_LEN read as 0.
  - Bytes beyond MAX_KEY_LEN total are truncated; the unused key tail is 0.
  - The key is registered; idx is set to 0; next state is SEARCH.
- SEARCH:
  - Each cycle compares the entry at idx: hit iff valid and the full MAX_KEY_LEN key is equal.
  - On hit: register is_match_o=1, hit_idx_o=idx, args_o=entry value; copy latched pkt_hdr, parsed_hdrs and out_port to the outputs; pulse ready_o; go to IDLE.
  - On miss at idx=NUM_ENTRIES-1: same, but with is_match_o=0, hit_idx_o=0, args_o=0.
  - Otherwise idx increments.
  - The lowest-index matching entry wins.
- Latency, counting the edge sampling start_i as edge 0:
  - Hit at entry i: ready_o high after edge 2+i.
  - Miss: ready_o high after edge NUM_ENTRIES+1.
- ready_o is high exactly one cycle. Data outputs hold until the next result.
- busy_o is combinational from state.
- start_i, mod_start_i and tbl_wr_i while busy are ignored. The upstream parser and control plane must observe busy_o.
- A layout of all-zero descriptors gives an empty key, which matches the first valid entry whose stored key is all zero.
- rst mid-search aborts the search: no ready_o pulse, and the state returns to IDLE with reset values.

Test Plan:
- Layout: field0 = {hdr1, off 16, len 4} with parsed_hdrs[1]=14, so the key is bytes 30..33. Entry 3 holds key C0 A8 00 01 and args 01 02. Send a header with those bytes.
  - Required: ready_o after edge 5, is_match_o=1, hit_idx_o=3, args_o[0..1]=01 02, pkt_hdr_o equal to input.
- Same header with byte 33 = 02: ready_o after edge 17, is_match_o=0, args_o all zero, out_port_o = out_port_i.
- Entries 2 and 5 both valid with an identical key: hit_idx_o=2.
- Two fields {hdr0, off 0, len 12} and {hdr0, off 12, len 8}: the key holds bytes 0..15 only.
  - Entry key = those 16 bytes: hit.
- start_i and tbl_wr_i asserted in the same IDLE cycle: write lands and no ready_o follows.
  - start_i during SEARCH: ignored, only one ready_o.
- rst asserted on edge 3 of a search: no ready_o, all outputs 0, all entries invalid.
  - A subsequent lookup misses.

Source files
------------

// File: rtl/match_table.sv
// Exact-match lookup: builds a key from up to KEY_FIELDS header field descriptors, then linearly searches a register table.
// Latency: ready_o pulses after edge 2+i for a hit at entry i, after edge NUM_ENTRIES+1 on a miss (start_i sampled on edge 0).
// Backpressure: none; busy_o is high outside IDLE and start_i / mod_start_i / tbl_wr_i are ignored while it is high.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start_i                  one-cycle packet valid; latches pkt_hdr_i, parsed_hdrs_i, out_port_i
//   pkt_hdr_i                header bytes, byte n at bits [8n +: 8]
//   parsed_hdrs_i            32-bit byte offset of header h at bits [32h +: 32]
//   out_port_i               port bitmap from the parser
//   ready_o                  one-cycle result valid; data outputs hold until the next result
//   busy_o                   high whenever the FSM is not IDLE
//   is_match_o, hit_idx_o    hit flag and matching entry (0 on miss)
//   args_o                   action args of the hit entry (0 on miss)
//   pkt_hdr_o, parsed_hdrs_o, out_port_o   registered pass-through of the latched packet
//   mod_start_i              load key layout; descriptor k at [16k +: 16] = {hdr[15:12], off[11:6], len[5:0]}
//   tbl_wr_i                 write key/value/valid at tbl_wr_idx_i (keys zero-padded, byte 0 at LSB)

module match_table #(
    parameter int HDR_MAX_LEN = 128,
    parameter int NUM_HEADERS = 16,
    parameter int KEY_FIELDS  = 4,
    parameter int MAX_KEY_LEN = 16,
    parameter int MAX_VAL_LEN = 16,
    parameter int NUM_ENTRIES = 16,
    parameter int NUM_PORTS   = 8,
    localparam int IDX_W      = $clog2(NUM_ENTRIES),
    localparam int HDR_W      = $clog2(HDR_MAX_LEN)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_i,
    input  logic [8*HDR_MAX_LEN-1:0]     pkt_hdr_i,
    input  logic [32*NUM_HEADERS-1:0]    parsed_hdrs_i,
    input  logic [NUM_PORTS-1:0]         out_port_i,
    output logic                         ready_o,
    output logic                         busy_o,
    output logic                         is_match_o,
    output logic [IDX_W-1:0]             hit_idx_o,
    output logic [8*MAX_VAL_LEN-1:0]     args_o,
    output logic [8*HDR_MAX_LEN-1:0]     pkt_hdr_o,
    output logic [32*NUM_HEADERS-1:0]    parsed_hdrs_o,
    output logic [NUM_PORTS-1:0]         out_port_o,
    input  logic                         mod_start_i,
    input  logic [16*KEY_FIELDS-1:0]     mod_key_fields_i,
    input  logic                         tbl_wr_i,
    input  logic [IDX_W-1:0]             tbl_wr_idx_i,
    input  logic                         tbl_wr_valid_i,
    input  logic [8*MAX_KEY_LEN-1:0]     tbl_wr_key_i,
    input  logic [8*MAX_VAL_LEN-1:0]     tbl_wr_val_i
);

    typedef enum logic [1:0] {IDLE, EXTRACT, SEARCH} state_t;

    state_t                       r_state;
    state_t                       w_state_nxt;

    logic [16*KEY_FIELDS-1:0]     r_desc;
    logic [NUM_ENTRIES-1:0]       r_tbl_vld;
    logic [8*MAX_KEY_LEN-1:0]     r_tbl_key [NUM_ENTRIES];
    logic [8*MAX_VAL_LEN-1:0]     r_tbl_val [NUM_ENTRIES];

    logic [8*HDR_MAX_LEN-1:0]     r_pkt_hdr;
    logic [32*NUM_HEADERS-1:0]    r_parsed;
    logic [NUM_PORTS-1:0]         r_out_port;
    logic [8*MAX_KEY_LEN-1:0]     r_key;
    logic [IDX_W-1:0]             r_idx;

    logic                         r_ready;
    logic                         r_is_match;
    logic [IDX_W-1:0]             r_hit_idx;
    logic [8*MAX_VAL_LEN-1:0]     r_args;
    logic [8*HDR_MAX_LEN-1:0]     r_pkt_hdr_o;
    logic [32*NUM_HEADERS-1:0]    r_parsed_o;
    logic [NUM_PORTS-1:0]         r_out_port_o;

    logic                         w_cfg;
    logic                         w_hit;
    logic                         w_last;
    logic [8*MAX_KEY_LEN-1:0]     w_key;
    logic [15:0]                  w_desc;
    logic [31:0]                  w_len;
    logic [31:0]                  w_pos;
    logic [31:0]                  w_base;
    logic [33:0]                  w_addr;

    // Control-plane writes win over a packet arriving in the same IDLE cycle.
    assign w_cfg  = (r_state == IDLE) && (mod_start_i || tbl_wr_i);
    assign w_hit  = r_tbl_vld[r_idx] && (r_tbl_key[r_idx] == r_key);
    assign w_last = (r_idx == IDX_W'(NUM_ENTRIES - 1));
    assign busy_o = (r_state != IDLE);

    // Key builder: w_pos is the running key byte position; each key byte j
    // falling inside [w_pos, w_pos+len) takes header byte base+off+(j-w_pos).
    // Bytes past MAX_KEY_LEN are simply never produced, which truncates.
    always_comb begin
        w_key  = '0;
        w_pos  = '0;
        w_desc = '0;
        w_len  = '0;
        w_base = '0;
        w_addr = '0;
        for (int k = 0; k < KEY_FIELDS; k++) begin
            w_desc = r_desc[16*k +: 16];
            w_len  = 32'(w_desc[5:0]);
            w_base = r_parsed[{w_desc[15:12], 5'b00000} +: 32];
            for (int j = 0; j < MAX_KEY_LEN; j++) begin
                if ((32'(j) >= w_pos) && (32'(j) < w_pos + w_len)) begin
                    w_addr = {2'b00, w_base} + 34'(w_desc[11:6]) + 34'(j) - {2'b00, w_pos};
                    if (w_addr < 34'(HDR_MAX_LEN)) begin
                        w_key[8*j +: 8] = r_pkt_hdr[{w_addr[HDR_W-1:0], 3'b000} +: 8];
                    end
                end
            end
            w_pos = w_pos + w_len;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start_i && !w_cfg) w_state_nxt = EXTRACT;
            EXTRACT: w_state_nxt = SEARCH;
            SEARCH:  if (w_hit || w_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_desc       <= '0;
            r_tbl_vld    <= '0;
            r_pkt_hdr    <= '0;
            r_parsed     <= '0;
            r_out_port   <= '0;
            r_key        <= '0;
            r_idx        <= '0;
            r_ready      <= 1'b0;
            r_is_match   <= 1'b0;
            r_hit_idx    <= '0;
            r_args       <= '0;
            r_pkt_hdr_o  <= '0;
            r_parsed_o   <= '0;
            r_out_port_o <= '0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (mod_start_i) begin
                        r_desc <= mod_key_fields_i;
                    end
                    if (tbl_wr_i) begin
                        r_tbl_vld[tbl_wr_idx_i] <= tbl_wr_valid_i;
                    end
                    if (start_i && !w_cfg) begin
                        r_pkt_hdr  <= pkt_hdr_i;
                        r_parsed   <= parsed_hdrs_i;
                        r_out_port <= out_port_i;
                    end
                end
                EXTRACT: begin
                    r_key <= w_key;
                    r_idx <= '0;
                end
                SEARCH: begin
                    if (w_hit || w_last) begin
                        r_ready      <= 1'b1;
                        r_is_match   <= w_hit;
                        r_hit_idx    <= w_hit ? r_idx : '0;
                        r_args       <= w_hit ? r_tbl_val[r_idx] : '0;
                        r_pkt_hdr_o  <= r_pkt_hdr;
                        r_parsed_o   <= r_parsed;
                        r_out_port_o <= r_out_port;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Entry keys and values carry no reset; the valid bits gate them.
    always_ff @(posedge clk) begin
        if ((r_state == IDLE) && tbl_wr_i) begin
            r_tbl_key[tbl_wr_idx_i] <= tbl_wr_key_i;
            r_tbl_val[tbl_wr_idx_i] <= tbl_wr_val_i;
        end
    end

    assign ready_o       = r_ready;
    assign is_match_o    = r_is_match;
    assign hit_idx_o     = r_hit_idx;
    assign args_o        = r_args;
    assign pkt_hdr_o     = r_pkt_hdr_o;
    assign parsed_hdrs_o = r_parsed_o;
    assign out_port_o    = r_out_port_o;

endmodule

// File: tb/tb_match_table.sv
module tb_match_table;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start_i = 1'b0;
    logic [1023:0]  pkt_hdr_i = '0;
    logic [511:0]   parsed_hdrs_i = '0;
    logic [7:0]     out_port_i = '0;
    logic           ready_o, busy_o, is_match_o;
    logic [3:0]     hit_idx_o;
    logic [127:0]   args_o;
    logic [1023:0]  pkt_hdr_o;
    logic [511:0]   parsed_hdrs_o;
    logic [7:0]     out_port_o;
    logic           mod_start_i = 1'b0;
    logic [63:0]    mod_key_fields_i = '0;
    logic           tbl_wr_i = 1'b0;
    logic [3:0]     tbl_wr_idx_i = '0;
    logic           tbl_wr_valid_i = 1'b0;
    logic [127:0]   tbl_wr_key_i = '0;
    logic [127:0]   tbl_wr_val_i = '0;

    int checks = 0;
    int failures = 0;

    match_table dut (
        .clk(clk), .rst(rst), .start_i(start_i), .pkt_hdr_i(pkt_hdr_i),
        .parsed_hdrs_i(parsed_hdrs_i), .out_port_i(out_port_i),
        .ready_o(ready_o), .busy_o(busy_o), .is_match_o(is_match_o),
        .hit_idx_o(hit_idx_o), .args_o(args_o), .pkt_hdr_o(pkt_hdr_o),
        .parsed_hdrs_o(parsed_hdrs_o), .out_port_o(out_port_o),
        .mod_start_i(mod_start_i), .mod_key_fields_i(mod_key_fields_i),
        .tbl_wr_i(tbl_wr_i), .tbl_wr_idx_i(tbl_wr_idx_i),
        .tbl_wr_valid_i(tbl_wr_valid_i), .tbl_wr_key_i(tbl_wr_key_i),
        .tbl_wr_val_i(tbl_wr_val_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; the DUT samples on the rising edge.
    task automatic tbl_write(input logic [3:0] idx, input logic vld, input logic [127:0] key, input logic [127:0] val);
        tbl_wr_i = 1'b1; tbl_wr_idx_i = idx; tbl_wr_valid_i = vld;
        tbl_wr_key_i = key; tbl_wr_val_i = val;
        @(posedge clk); @(negedge clk);
        tbl_wr_i = 1'b0;
    endtask

    task automatic set_layout(input logic [63:0] desc);
        mod_start_i = 1'b1; mod_key_fields_i = desc;
        @(posedge clk); @(negedge clk);
        mod_start_i = 1'b0;
    endtask

    // Returns the edge number after which ready_o was first seen (-1 if never),
    // plus busy_o as observed just after edge 0.
    task automatic lookup(input logic [1023:0] hdr, input logic [511:0] ph, input logic [7:0] port,
                          output int edges, output logic busy0);
        pkt_hdr_i = hdr; parsed_hdrs_i = ph; out_port_i = port; start_i = 1'b1;
        @(posedge clk); @(negedge clk);
        start_i = 1'b0;
        busy0 = busy_o;
        edges = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); @(negedge clk);
            if (ready_o) begin edges = n; break; end
        end
    endtask

    task automatic count_ready(input int cycles, output int cnt);
        cnt = 0;
        for (int n = 0; n < cycles; n++) begin
            @(posedge clk); @(negedge clk);
            if (ready_o) cnt++;
        end
    endtask

    logic [1023:0] hdr_a, hdr_b, hdr_c, hdr_d;
    logic [511:0]  ph;
    int            edges, cnt;
    logic          busy0;

    initial begin
        for (int i = 0; i < 128; i++) hdr_a[8*i +: 8] = 8'(i) ^ 8'h5A;
        hdr_a[8*30 +: 8] = 8'hC0; hdr_a[8*31 +: 8] = 8'hA8;
        hdr_a[8*32 +: 8] = 8'h00; hdr_a[8*33 +: 8] = 8'h01;
        hdr_b = hdr_a; hdr_b[8*33 +: 8] = 8'h02;
        hdr_c = hdr_a; hdr_c[8*33 +: 8] = 8'h07;
        hdr_d = hdr_a; hdr_d[8*33 +: 8] = 8'h09;
        ph = '0; ph[63:32] = 32'd14; ph[95:64] = 32'd40;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_ready", ready_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_match", is_match_o, 0);
        check("rst_hit_idx", hit_idx_o, 0);
        check("rst_args", args_o, 0);
        check("rst_pkt_hdr", pkt_hdr_o, 0);
        check("rst_parsed", parsed_hdrs_o, 0);
        check("rst_port", out_port_o, 0);

        // Layout {hdr1, off16, len4} loaded in the same cycle as an entry write.
        tbl_wr_i = 1'b1; tbl_wr_idx_i = 4'd3; tbl_wr_valid_i = 1'b1;
        tbl_wr_key_i = 128'h0100A8C0; tbl_wr_val_i = 128'h0201;
        set_layout(64'h1404);
        tbl_wr_i = 1'b0;

        lookup(hdr_a, ph, 8'h21, edges, busy0);
        check("hit_busy", busy0, 1);
        check("hit_latency", 32'(edges), 32'd5);
        check("hit_match", is_match_o, 1);
        check("hit_idx", hit_idx_o, 4'd3);
        check("hit_args", args_o, 128'h0201);
        check("hit_pkt_hdr", pkt_hdr_o, hdr_a);
        check("hit_parsed", parsed_hdrs_o, ph);
        check("hit_port", out_port_o, 8'h21);
        @(posedge clk); @(negedge clk);
        check("ready_one_cycle", ready_o, 0);
        check("idle_busy", busy_o, 0);
        check("hold_args", args_o, 128'h0201);

        lookup(hdr_b, ph, 8'h84, edges, busy0);
        check("miss_latency", 32'(edges), 32'd17);
        check("miss_match", is_match_o, 0);
        check("miss_idx", hit_idx_o, 0);
        check("miss_args", args_o, 0);
        check("miss_port", out_port_o, 8'h84);
        check("miss_pkt_hdr", pkt_hdr_o, hdr_b);

        tbl_write(4'd5, 1'b1, 128'h0200A8C0, 128'hAA05);
        tbl_write(4'd2, 1'b1, 128'h0200A8C0, 128'hAA02);
        lookup(hdr_b, ph, 8'h01, edges, busy0);
        check("prio_latency", 32'(edges), 32'd4);
        check("prio_idx", hit_idx_o, 4'd2);
        check("prio_args", args_o, 128'hAA02);

        // start_i alongside a table write: the write lands, the packet is dropped.
        pkt_hdr_i = hdr_c; start_i = 1'b1;
        tbl_write(4'd7, 1'b1, 128'h0700A8C0, 128'h77);
        start_i = 1'b0;
        check("drop_busy", busy_o, 0);
        count_ready(20, cnt);
        check("drop_no_ready", 32'(cnt), 0);
        lookup(hdr_c, ph, 8'h02, edges, busy0);
        check("wr_landed_latency", 32'(edges), 32'd9);
        check("wr_landed_idx", hit_idx_o, 4'd7);
        check("wr_landed_args", args_o, 128'h77);

        // A second start_i during SEARCH must not spawn another result.
        pkt_hdr_i = hdr_d; start_i = 1'b1;
        @(posedge clk); @(negedge clk);
        start_i = 1'b0;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        check("search_busy", busy_o, 1);
        start_i = 1'b1;
        @(posedge clk); @(negedge clk);
        start_i = 1'b0;
        count_ready(30, cnt);
        check("busy_start_one_ready", 32'(cnt), 1);
        check("busy_start_miss", is_match_o, 0);

        // Two fields totalling 20 bytes: only header bytes 0..15 form the key.
        set_layout({32'h0, 16'h0308, 16'h000C});
        tbl_write(4'd9, 1'b1, hdr_a[127:0], 128'h99);
        lookup(hdr_a, ph, 8'h10, edges, busy0);
        check("trunc_latency", 32'(edges), 32'd11);
        check("trunc_idx", hit_idx_o, 4'd9);
        check("trunc_args", args_o, 128'h99);

        // Reset sampled on edge 3 of a search.
        pkt_hdr_i = hdr_d; out_port_i = 8'h55; start_i = 1'b1;
        @(posedge clk); @(negedge clk);
        start_i = 1'b0;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        check("abort_ready", ready_o, 0);
        check("abort_busy", busy_o, 0);
        check("abort_match", is_match_o, 0);
        check("abort_idx", hit_idx_o, 0);
        check("abort_args", args_o, 0);
        check("abort_pkt_hdr", pkt_hdr_o, 0);
        check("abort_port", out_port_o, 0);
        count_ready(20, cnt);
        check("abort_no_ready", 32'(cnt), 0);
        lookup(hdr_a, ph, 8'h03, edges, busy0);
        check("post_rst_latency", 32'(edges), 32'd17);
        check("post_rst_match", is_match_o, 0);

        // Descriptors are zero after reset: the empty key hits an all-zero entry.
        tbl_write(4'd4, 1'b1, 128'h0, 128'h44);
        lookup(hdr_a, ph, 8'h03, edges, busy0);
        check("empty_key_latency", 32'(edges), 32'd6);
        check("empty_key_idx", hit_idx_o, 4'd4);
        check("empty_key_args", args_o, 128'h44);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
